rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised N-channel arbitrated multiplexer with a one-entry registered output stage. It is the sequential successor to the fixed-select 3-to-1 datapath mux.
- Each cycle it picks one of N valid/ready producers and captures that producer's word into an output register. The register drives a valid/ready consumer.
- Used wherever several pipeline sources share one sink, e.g. memory-port sharing or writeback merging.
- Arbitration mode is selected by parameter: round-robin or fixed priority.

Parameters:
- WIDTH, 32, data width per channel.
- N, 3, channel count; legal range 2..16, not restricted to powers of 2.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SEL_W, derived localparam, equal to clog2(N); not overridable.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  N*WIDTH  flattened inputs; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel request.
- in_ready  out  N  per-channel grant/accept, one-hot or zero.
- out_data  out  WIDTH  registered selected word.
- out_sel  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset values (asynchronous, immediate on rst=1): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - While rst=1, in_ready is forced to all zeros.
  - A word held at reset assertion is discarded. There is no recovery.
- free = !out_valid || out_ready. The output register can load this cycle.
- Grant g is computed combinationally every cycle from in_valid and ptr:
  - RR=1: first valid channel scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - RR=0: lowest-index valid channel; ptr is ignored.
- in_ready[g] = free && |in_valid; all other in_ready bits are 0.
  - in_ready never asserts for a channel whose in_valid is 0.
  - Combinational paths out_ready->in_ready and in_valid->in_ready are permitted and documented.
- Transfer on in_valid[g] && in_ready[g]. Next edge: out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - Latency is 1 cycle, input handshake to out_valid.
  - Throughput is 1 word/cycle with out_ready held high.
- Pop without refill (out_valid && out_ready && no in_valid): out_valid <= 0. out_data and out_sel keep their last values.
- Simultaneous pop and refill in the same cycle: the new word loads and out_valid stays 1. There is no bubble.
- Backpressure (out_valid && !out_ready): out_data, out_sel and out_valid stay stable; in_ready = 0.
- Pointer update, RR=1 only, and only on a transfer: ptr <= (g == N-1) ? 0 : g+1.
  - The wrap is explicit, so non-power-of-2 N never produces an out-of-range ptr.
  - With no transfer, ptr holds.
- Producers may deassert in_valid without a handshake. Arbitration is recomputed every cycle and no grant is latched.
- out_sel reflects the channel of the word currently in out_data, not the live grant.
- No X propagation: with zero valid inputs, out_data is never loaded.

Test Plan:
- Reset: assert rst mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 before the next edge; in_ready=3'b000 while rst=1.
- Single channel (N=3, RR=1): in_valid=3'b010, ch1 data=32'hA5A5_0001, out_ready=1 -> in_ready=3'b010 in cycle 0; cycle 1 gives out_valid=1, out_data=32'hA5A5_0001, out_sel=1.
- Round-robin fairness: in_valid=3'b111 held, out_ready=1, distinct data per channel -> grants 0,1,2,0,1,2; out_sel shows the same sequence delayed 1 cycle; no gaps in out_valid.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with all channels valid -> in_ready=0 and out_data constant throughout. Raising out_ready -> same-cycle grant of the next RR channel; new word appears the next cycle with out_valid continuous.
- Wrap / non-power-of-2: ptr=2 after a grant of ch1; only ch0 valid -> grant 0, ptr becomes 1. A grant of ch2 -> ptr becomes 0, never 3.
- Fixed priority (RR=0): in_valid=3'b111 held -> ch0 granted every cycle and ch2 never granted. Dropping ch0 and ch1 valid -> ch2 granted in that same cycle.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated mux (round-robin or fixed priority) with a one-entry output register.
// Latency: 1 cycle from input handshake to out_valid. A stalled output deasserts every in_ready.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int RR    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_sel,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int SEL_W = $clog2(N);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] gnt;
    logic             any_vld;
    logic             free;
    logic             xfer;
    logic [WIDTH-1:0] gnt_dat;
    int               idx;

    // Scan starts at ptr in round-robin mode, at 0 in fixed-priority mode.
    always_comb begin
        gnt     = '0;
        any_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (RR != 0) ? int'(ptr) + k : k;
            if (idx >= N) idx = idx - N;
            if (!any_vld && in_valid[idx]) begin
                any_vld = 1'b1;
                gnt     = idx[SEL_W-1:0];
            end
        end
    end

    assign gnt_dat = in_data[int'(gnt)*WIDTH +: WIDTH];
    assign free    = !out_valid || out_ready;
    assign xfer    = free && any_vld && !rst;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = xfer && (gnt == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_dat;
            out_sel   <= gnt;
            // Explicit wrap keeps ptr in range for non-power-of-2 N.
            if (RR != 0) ptr <= (gnt == SEL_W'(N-1)) ? '0 : gnt + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: one round-robin and one fixed-priority instance, scoreboard-checked.
module tb_rr_arb_mux;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] in_data;
    logic [31:0] chd [3];

    logic [2:0]  rv, rrdy, fv, frdy;
    logic [31:0] rdat, fdat;
    logic [1:0]  rsel, fsel;
    logic        rval, rordy, fval, fordy;

    exp_t qr[$];
    exp_t qf[$];
    int   checks = 0;
    int   failures = 0;

    rr_arb_mux #(.WIDTH(32), .N(3), .RR(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(rv), .in_ready(rrdy),
        .out_data(rdat), .out_sel(rsel), .out_valid(rval), .out_ready(rordy)
    );

    rr_arb_mux #(.WIDTH(32), .N(3), .RR(0)) u_fp (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(fv), .in_ready(frdy),
        .out_data(fdat), .out_sel(fsel), .out_valid(fval), .out_ready(fordy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever a word is consumed.
    always @(negedge clk) begin
        if (!rst && rval && rordy) begin
            if (qr.size() == 0) chk("rr_unexpected_word", {30'd0, rsel, rdat}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                exp_t e;
                e = qr.pop_front();
                chk("rr_out_data", {32'd0, rdat}, {32'd0, e.d});
                chk("rr_out_sel", {62'd0, rsel}, {62'd0, e.s});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && fval && fordy) begin
            if (qf.size() == 0) chk("fp_unexpected_word", {30'd0, fsel, fdat}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                exp_t e;
                e = qf.pop_front();
                chk("fp_out_data", {32'd0, fdat}, {32'd0, e.d});
                chk("fp_out_sel", {62'd0, fsel}, {62'd0, e.s});
            end
        end
    end

    // One cycle of stimulus: drive after the edge, push the expected word, check in_ready at negedge.
    task automatic cyc(input bit fp, input logic [2:0] v, input logic ordy,
                       input logic [2:0] exp_rdy, input logic [1:0] exp_sel);
        exp_t e;
        @(posedge clk);
        #1;
        if (fp) begin fv = v; fordy = ordy; end
        else    begin rv = v; rordy = ordy; end
        if (exp_rdy != 3'b000) begin
            e.d = chd[exp_sel];
            e.s = exp_sel;
            if (fp) qf.push_back(e);
            else    qr.push_back(e);
        end
        @(negedge clk);
        if (fp) chk("fp_in_ready", {61'd0, frdy}, {61'd0, exp_rdy});
        else    chk("rr_in_ready", {61'd0, rrdy}, {61'd0, exp_rdy});
    endtask

    initial begin
        chd[0] = 32'h1000_0000;
        chd[1] = 32'hA5A5_0001;
        chd[2] = 32'h2000_0002;
        in_data = {chd[2], chd[1], chd[0]};
        rv = 3'b111; rordy = 1'b1;
        fv = 3'b111; fordy = 1'b1;

        // Reset state
        #3;
        chk("rst_out_valid", {63'd0, rval}, 64'd0);
        chk("rst_out_data", {32'd0, rdat}, 64'd0);
        chk("rst_out_sel", {62'd0, rsel}, 64'd0);
        chk("rst_in_ready_rr", {61'd0, rrdy}, 64'd0);
        chk("rst_in_ready_fp", {61'd0, frdy}, 64'd0);
        rv = 3'b000; fv = 3'b000;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single channel, then wrap: ptr 2 -> grant 0 -> ptr 1 -> grant 2 -> ptr 0
        cyc(0, 3'b010, 1'b1, 3'b010, 2'd1);
        cyc(0, 3'b001, 1'b1, 3'b001, 2'd0);
        cyc(0, 3'b101, 1'b1, 3'b100, 2'd2);

        // Fairness with all channels requesting
        for (int i = 0; i < 6; i++) begin
            logic [2:0] oh;
            oh = 3'b001 << (i % 3);
            cyc(0, 3'b111, 1'b1, oh, 2'(i % 3));
            if (i > 0) chk("rr_no_gap", {63'd0, rval}, 64'd1);
        end

        // Backpressure: held word ch2 stays put, no grants
        for (int i = 0; i < 5; i++) begin
            cyc(0, 3'b111, 1'b0, 3'b000, 2'd0);
            chk("bp_out_valid", {63'd0, rval}, 64'd1);
            chk("bp_out_data", {32'd0, rdat}, {32'd0, 32'h2000_0002});
            chk("bp_out_sel", {62'd0, rsel}, 64'd2);
        end

        // Release: same-cycle grant of ch0, continuous out_valid
        cyc(0, 3'b111, 1'b1, 3'b001, 2'd0);
        cyc(0, 3'b000, 1'b1, 3'b000, 2'd0);
        chk("refill_out_valid", {63'd0, rval}, 64'd1);
        cyc(0, 3'b000, 1'b1, 3'b000, 2'd0);
        chk("pop_out_valid", {63'd0, rval}, 64'd0);
        chk("pop_hold_data", {32'd0, rdat}, {32'd0, 32'h1000_0000});
        chk("pop_hold_sel", {62'd0, rsel}, 64'd0);

        // Mid-cycle reset with a held word (ptr is 2 before reset)
        cyc(0, 3'b010, 1'b0, 3'b010, 2'd1);
        @(posedge clk);
        #1 rv = 3'b000;
        chk("pre_rst_out_valid", {63'd0, rval}, 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, rval}, 64'd0);
        chk("midrst_out_data", {32'd0, rdat}, 64'd0);
        chk("midrst_out_sel", {62'd0, rsel}, 64'd0);
        qr.delete();
        rv = 3'b111; rordy = 1'b1;
        #1;
        chk("midrst_in_ready", {61'd0, rrdy}, 64'd0);
        @(posedge clk);
        #1 begin rst = 1'b0; rv = 3'b000; end
        cyc(0, 3'b111, 1'b1, 3'b001, 2'd0);
        cyc(0, 3'b000, 1'b1, 3'b000, 2'd0);

        // Fixed priority: ch0 always wins, ch2 wins once ch0/ch1 drop
        for (int i = 0; i < 4; i++) cyc(1, 3'b111, 1'b1, 3'b001, 2'd0);
        cyc(1, 3'b100, 1'b1, 3'b100, 2'd2);
        cyc(1, 3'b000, 1'b1, 3'b000, 2'd0);
        cyc(1, 3'b000, 1'b1, 3'b000, 2'd0);

        chk("rr_queue_empty", 64'(qr.size()), 64'd0);
        chk("fp_queue_empty", 64'(qf.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
